// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into
// 32-bit words, writes them to consecutive word addresses, then verifies an
// XOR checksum byte that trails the payload.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [10:0]           word_count,
  input  logic                  abort,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [10:0] MAX_CNT = 11'(MAX_WORDS);

  state_t                state, state_next;
  logic [10:0]           count;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [1:0]            byte_idx;
  logic [7:0]            checksum;
  logic [31:0]           word;
  logic                  accept;
  logic                  len_ok;

  assign len_ok = (word_count != 11'd0) && (word_count <= MAX_CNT);

  // Next-state decode and per-state outputs; abort outranks byte acceptance.
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    mem_we     = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = len_ok ? LOAD : DONE;
      end
      LOAD: begin
        byte_ready = 1'b1;
        accept     = byte_valid && !abort;
        if (abort) state_next = DONE;
        else if (accept && byte_idx == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        if (abort) begin
          state_next = DONE;
        end else begin
          mem_we     = '1;
          state_next = (count == 11'd1) ? CHECK : LOAD;
        end
      end
      CHECK: begin
        byte_ready = 1'b1;
        accept     = byte_valid && !abort;
        if (abort || accept) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus datapath: byte assembly, checksum, counters, status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      word_addr <= '0;
      byte_idx  <= '0;
      checksum  <= '0;
      word      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      error     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              count     <= word_count;
              word_addr <= '0;
              byte_idx  <= '0;
              checksum  <= '0;
              error     <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            error <= 1'b1;
          end else if (accept) begin
            word[{byte_idx, 3'b000} +: 8] <= byte_in;
            byte_idx <= byte_idx + 2'd1;
            checksum <= checksum ^ byte_in;
            // Output registers load only on the way into WRITE so they
            // stay put while the next word is being assembled.
            if (byte_idx == 2'd3) begin
              mem_wdata <= {byte_in, word[23:0]};
              mem_addr  <= word_addr;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            error <= 1'b1;
          end else begin
            word_addr <= word_addr + ADDR_WIDTH'(1);
            count     <= count - 11'd1;
          end
        end
        CHECK: begin
          if (abort) error <= 1'b1;
          else if (accept && byte_in != checksum) error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte loads, checksum pass/fail, illegal
// lengths, abort during WRITE and reset during LOAD.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] word_count;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_we[$];
  logic [7:0]  bytes_q[$];

  imem_loader #(.ADDR_WIDTH(10), .MAX_WORDS(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Record every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we != 4'b0000) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_we.push_back(mem_we);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
    wr_we.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [10:0] n);
    start      = 1'b1;
    word_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit jitter);
    bit ok = 1'b0;
    if (jitter) repeat ($urandom_range(0, 2)) tick();
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    byte_valid = 1'b0;
    if (!ok) check("byte_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, seen}, 32'd1);
    if (seen) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  // Sends the payload in bytes_q followed by the checksum byte.
  task automatic run_load(input logic [10:0] n, input logic [7:0] chk, input bit jitter);
    clear_writes();
    pulse_start(n);
    foreach (bytes_q[i]) send_byte(bytes_q[i], jitter);
    send_byte(chk, jitter);
    wait_done("load_done");
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; word_count = '0; abort = 1'b0;
    byte_in = '0; byte_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we",    {28'd0, mem_we},     32'd0);
    check("rst_addr",  {22'd0, mem_addr},   32'd0);
    check("rst_wdata", mem_wdata,           32'd0);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_done",  {31'd0, done},       32'd0);
    check("rst_error", {31'd0, error},      32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single word.
    bytes_q = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_load(11'd1, 8'h13, 1'b0);
    check("w1_nwr",  wr_addr.size(), 32'd1);
    if (wr_addr.size() >= 1) begin
      check("w1_addr", {22'd0, wr_addr[0]}, 32'd0);
      check("w1_data", wr_data[0], 32'h0000_0013);
      check("w1_we",   {28'd0, wr_we[0]}, 32'hf);
    end
    check("w1_err", {31'd0, error}, 32'd0);
    check("w1_idle_busy", {31'd0, busy}, 32'd0);

    // Two words, little-endian lane order.
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(11'd2, 8'h08, 1'b0);
    check("w2_nwr", wr_addr.size(), 32'd2);
    if (wr_addr.size() >= 2) begin
      check("w2_a0", {22'd0, wr_addr[0]}, 32'd0);
      check("w2_d0", wr_data[0], 32'h0403_0201);
      check("w2_a1", {22'd0, wr_addr[1]}, 32'd1);
      check("w2_d1", wr_data[1], 32'h0807_0605);
    end
    check("w2_err", {31'd0, error}, 32'd0);

    // Checksum pass then fail.
    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(11'd1, 8'h00, 1'b0);
    check("ck_ok_err", {31'd0, error}, 32'd0);
    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(11'd1, 8'h01, 1'b0);
    check("ck_bad_nwr", wr_addr.size(), 32'd1);
    if (wr_addr.size() >= 1) check("ck_bad_data", wr_data[0], 32'hDDCC_BBAA);
    check("ck_bad_err", {31'd0, error}, 32'd1);

    // Illegal lengths.
    for (int k = 0; k < 2; k++) begin
      logic [10:0] n;
      n = (k == 0) ? 11'd0 : 11'd1025;
      clear_writes();
      pulse_start(n);
      @(negedge clk);
      check("bad_len_done", {31'd0, done},  32'd1);
      check("bad_len_err",  {31'd0, error}, 32'd1);
      tick();
      @(negedge clk);
      check("bad_len_idle", {30'd0, busy, done}, 32'd0);
      check("bad_len_nwr",  wr_addr.size(), 32'd0);
      tick();
    end

    // Abort on the second WRITE cycle of a 3-word load, with jittered valid.
    clear_writes();
    pulse_start(11'd3);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 8'h40), 1'b1);
    abort = 1'b1;
    @(negedge clk);
    check("abort_we", {28'd0, mem_we}, 32'd0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_done", {31'd0, done}, 32'd1);
    check("abort_err",  {31'd0, error}, 32'd1);
    check("abort_nwr",  wr_addr.size(), 32'd1);
    if (wr_addr.size() >= 1) begin
      check("abort_a0", {22'd0, wr_addr[0]}, 32'd0);
      check("abort_d0", wr_data[0], 32'h4342_4140);
    end
    tick();

    // Next start after abort is accepted and clears error.
    bytes_q = '{8'h13, 8'h00, 8'h00, 8'h00};
    run_load(11'd1, 8'h13, 1'b1);
    check("post_abort_nwr", wr_addr.size(), 32'd1);
    check("post_abort_err", {31'd0, error}, 32'd0);

    // Reset after two bytes of a load; preceding error set so reset is visible.
    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(11'd1, 8'h55, 1'b0);
    clear_writes();
    pulse_start(11'd1);
    send_byte(8'h99, 1'b0);
    send_byte(8'h98, 1'b0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy",  {31'd0, busy},       32'd0);
    check("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    check("mid_rst_done",  {31'd0, done},       32'd0);
    check("mid_rst_err",   {31'd0, error},      32'd0);
    check("mid_rst_wdata", mem_wdata,           32'd0);
    check("mid_rst_addr",  {22'd0, mem_addr},   32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_nwr", wr_addr.size(), 32'd0);
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(11'd1, 8'h44, 1'b0);
    check("rec_nwr", wr_addr.size(), 32'd1);
    if (wr_addr.size() >= 1) begin
      check("rec_addr", {22'd0, wr_addr[0]}, 32'd0);
      check("rec_data", wr_data[0], 32'h4433_2211);
    end
    check("rec_err", {31'd0, error}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
